vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing for the Pong display from the 50 MHz system clock.
- Sits directly upstream of every GUI component (paddles, ball, score). It feeds them the current pixel col/row, drives hsync/vsync to the connector, and supplies video_on to the pixel mixer.
- Also produces frame_tick, a once-per-frame pulse that serves as the game-update tick.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  reset, synchronous, active-high
pix_en  output  1  pixel-clock enable, high one clk in every CLK_DIV
col  output  10  current pixel column (raw horizontal counter)
row  output  10  current pixel row (raw vertical counter)
video_on  output  1  high when col < H_VISIBLE and row < V_VISIBLE
hsync  output  1  horizontal sync to connector
vsync  output  1  vertical sync to connector
line_tick  output  1  one-clk pulse when col wraps to 0
frame_tick  output  1  one-clk pulse at start of vertical blanking

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800).
  - V_TOTAL = sum of the V_* parameters (525).
  - Both must be <= 1024; this is an elaboration-time check.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1) && !reset. It is combinational from the div register.
  - With CLK_DIV=1, pix_en is 1 whenever reset is low.
- Counters (h, v) advance only on clk edges where pix_en=1:
  - If h == H_TOTAL-1: h -> 0, and v increments.
  - If v == V_TOTAL-1 at that wrap: v -> 0.
  - Otherwise h increments by 1.
- col = h and row = v, driven directly from the counter registers. They are not masked in blanking; downstream uses video_on.
- Registered decodes: hsync, vsync and video_on are registered. They load on the same edge as the counters, from the counters' next values, so all outputs are coherent for the whole pixel period.
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491); otherwise ~SYNC_ACTIVE.
- Tick pulses (registered, exactly one clk wide, never one pixel wide):
  - line_tick = 1 for the clk following the edge on which h wrapped to 0.
  - frame_tick = 1 for the clk following the edge on which (h,v) became (0, V_VISIBLE).
- Reset values (all outputs): div=0, h=v=0, col=0, row=0, pix_en=0, video_on=0, hsync=vsync=~SYNC_ACTIVE, line_tick=0, frame_tick=0.
- Boundary cases:
  - Post-reset first pixel: pixel (0,0) of the first frame after reset is blanked (video_on=0). The first pix_en edge loads (1,0) with video_on=1.
  - Reset mid-frame: any state returns to the reset values on the next clk edge. A pending tick is dropped.
  - Full wrap: (H_TOTAL-1, V_TOTAL-1) -> (0,0) with video_on=1 on the same pix_en edge. No tick is generated at this wrap except line_tick.
  - No pix_en, no change: on clk edges without pix_en, col/row/hsync/vsync/video_on hold. Ticks return to 0 after one clk.
- Latency: col/row change on the clk edge where pix_en=1, i.e. one clk after pix_en rises.

Test Plan:
- Reset held 5 clks -> col=0, row=0, video_on=0, hsync=vsync=1, pix_en=0, line_tick=frame_tick=0 throughout.
- Release reset, CLK_DIV=2 -> pix_en high on every 2nd clk. col increments by 1 per pix_en. line_tick period = 1600 clks. video_on falls as col goes 639->640.
- Horizontal timing -> hsync=0 exactly while col in 656..751 (192 clks). hsync=1 at col 655 and 752. col wraps 799->0 and row increments 0->1.
- Full frame -> frame_tick one clk wide, asserted one clk after (col,row) becomes (0,480). Period 840000 clks. vsync=0 only for rows 490..491 (3200 clks).
- Wrap -> from (799,524), the next pix_en gives (0,0), video_on=1, vsync=1, hsync=1, with line_tick but no frame_tick.
- Reset pulsed 1 clk at col=300, row=100 -> next clk col=row=0, video_on=0. Counting resumes and col=1 appears 2 clks after reset release.

Source files
------------

// File: rtl/vga_if.sv
// VGA raster bundle: pixel position, syncs, blanking and tick pulses.
// The timing generator drives it; GUI components and the mixer consume it.
interface vga_if;
  logic       pix_en;
  logic [9:0] col;
  logic [9:0] row;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       line_tick;
  logic       frame_tick;

  modport master (
    output pix_en, col, row, video_on,
    output hsync, vsync, line_tick, frame_tick
  );

  modport slave (
    input pix_en, col, row, video_on,
    input hsync, vsync, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing from the system clock via a pixel enable.
// Syncs, blanking and ticks are registered from the counters' next values.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 2,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input logic  clk,
  input logic  reset,
  vga_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
  endgenerate

  logic [DW-1:0] div;
  logic [9:0]    h, v;
  logic [9:0]    h_nxt, v_nxt;
  logic          div_last;
  logic          hs_on, vs_on, vis_nxt;

  assign div_last   = (div == DW'(CLK_DIV - 1));
  assign vga.pix_en = div_last && !reset;
  assign vga.col    = h;
  assign vga.row    = v;

  always_comb begin
    h_nxt = h + 10'd1;
    v_nxt = v;
    if (h == 10'(H_TOTAL - 1)) begin
      h_nxt = '0;
      if (v == 10'(V_TOTAL - 1)) v_nxt = '0;
      else                       v_nxt = v + 10'd1;
    end
  end

  // 11-bit compares so a sync window ending at 1024 still decodes
  assign hs_on = ({1'b0, h_nxt} >= 11'(HS_LO)) &&
                 ({1'b0, h_nxt} <  11'(HS_HI));
  assign vs_on = ({1'b0, v_nxt} >= 11'(VS_LO)) &&
                 ({1'b0, v_nxt} <  11'(VS_HI));
  assign vis_nxt = ({1'b0, h_nxt} < 11'(H_VISIBLE)) &&
                   ({1'b0, v_nxt} < 11'(V_VISIBLE));

  always_ff @(posedge clk) begin
    if (reset) begin
      div            <= '0;
      h              <= '0;
      v              <= '0;
      vga.video_on   <= 1'b0;
      vga.hsync      <= ~SYNC_ACTIVE;
      vga.vsync      <= ~SYNC_ACTIVE;
      vga.line_tick  <= 1'b0;
      vga.frame_tick <= 1'b0;
    end else begin
      div <= div_last ? '0 : div + DW'(1);
      vga.line_tick  <= 1'b0;
      vga.frame_tick <= 1'b0;
      if (div_last) begin
        h              <= h_nxt;
        v              <= v_nxt;
        vga.video_on   <= vis_nxt;
        vga.hsync      <= hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vga.vsync      <= vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vga.line_tick  <= (h_nxt == '0);
        vga.frame_tick <= (h_nxt == '0) &&
                          (v_nxt == 10'(V_VISIBLE));
      end
    end
  end

endmodule
